// File: rtl/dpc_pkg.sv
// Shared DPC types: frame-guard FSM states and the AXIS pixel record.
// The DPC core and the skid buffer use the same record.
package dpc_pkg;

  localparam int PIX_W = 14;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } fg_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] tdata;
    logic             tuser;
    logic             tlast;
  } axis_pix_t;

endpackage

// File: rtl/dpc_frame_guard_if.sv
// AXI4-Stream pixel link (tvalid/tready, tdata, tuser=SOF, tlast=EOL).
// master drives payload and tvalid, slave drives tready.
interface dpc_frame_guard_if #(
  parameter int DW = 14
) ();
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;

  modport master (
    output tvalid, tdata, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer for axis_pix_t, registered outputs, 1 beat/cycle.
// Ports: i_valid/i_data in (o_full = no room), o_valid/o_data/i_ready out.
module axis_skid_buf
  import dpc_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_valid,
  input  axis_pix_t i_data,
  output logic      o_full,
  output logic      o_valid,
  input  logic      i_ready,
  output axis_pix_t o_data
);

  logic      r_hv;
  logic      r_sv;
  axis_pix_t r_hd;
  axis_pix_t r_sd;
  logic      w_push;

  // The skid entry is only ever occupied behind a stalled head.
  assign w_push = i_valid && !r_sv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hv <= 1'b0;
      r_sv <= 1'b0;
      r_hd <= '0;
      r_sd <= '0;
    end else if (!r_hv || i_ready) begin
      if (r_sv) begin
        r_hv <= 1'b1;
        r_hd <= r_sd;
        r_sv <= 1'b0;
      end else begin
        r_hv <= w_push;
        if (w_push) r_hd <= i_data;
      end
    end else if (w_push) begin
      r_sv <= 1'b1;
      r_sd <= i_data;
    end
  end

  assign o_full  = r_sv;
  assign o_valid = r_hv;
  assign o_data  = r_hd;

endmodule

// File: rtl/dpc_frame_guard.sv
// Frame guard ahead of the DPC core: regenerates tuser/tlast, drops strays.
// Ports: axis clk/rstn, s_axis/m_axis links, width/height, error counters.
module dpc_frame_guard
  import dpc_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = PIX_W,
  parameter int DIM_WIDTH        = 16,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                     axis_aclk,
  input  logic                     axis_aresetn,
  dpc_frame_guard_if.slave         s_axis,
  dpc_frame_guard_if.master        m_axis,
  input  logic [DIM_WIDTH-1:0]     width,
  input  logic [DIM_WIDTH-1:0]     height,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] frame_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] line_err_cnt,
  output logic                     frame_done,
  output logic                     busy
);

  fg_state_t            r_state;
  logic [DIM_WIDTH-1:0] r_w, r_h, r_col, r_row;
  logic [DIM_WIDTH-1:0] w_cw, w_ch, w_c, w_r;
  logic                 w_full, w_acc, w_sof_ok, w_fwd;
  logic                 w_lastc, w_lastr, w_ferr, w_lerr;
  logic                 r_done, w_ov;
  axis_pix_t            w_in, w_out;

  // Non-SOF pixels outside a frame are always drained.
  assign s_axis.tready = (r_state == ACTIVE || s_axis.tuser) ? !w_full : 1'b1;
  assign w_acc    = s_axis.tvalid && s_axis.tready;
  assign w_sof_ok = s_axis.tuser && (width != '0) && (height != '0);

  // A SOF pixel is handled as col 0 / row 0 of the newly latched frame.
  always_comb begin
    w_cw = r_w;
    w_ch = r_h;
    w_c  = r_col;
    w_r  = r_row;
    if (s_axis.tuser) begin
      w_cw = width;
      w_ch = height;
      w_c  = '0;
      w_r  = '0;
    end
    w_lastc = (w_c == w_cw - 1'b1);
    w_lastr = (w_r == w_ch - 1'b1);
    w_fwd   = w_acc && (s_axis.tuser ? w_sof_ok : (r_state == ACTIVE));
    w_ferr  = w_acc && (r_state == ACTIVE) && s_axis.tuser;
    w_lerr  = w_acc && (r_state == ACTIVE) && !s_axis.tuser
              && (s_axis.tlast != w_lastc);
    w_in    = '{tdata: s_axis.tdata, tuser: s_axis.tuser, tlast: w_lastc};
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state <= WAIT_SOF;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fwd) begin
        r_w <= w_cw;
        r_h <= w_ch;
        if (w_lastc) begin
          r_col <= '0;
          if (w_lastr) begin
            r_row   <= '0;
            r_done  <= 1'b1;
            r_state <= WAIT_SOF;
          end else begin
            r_row   <= w_r + 1'b1;
            r_state <= ACTIVE;
          end
        end else begin
          r_col   <= w_c + 1'b1;
          r_row   <= w_r;
          r_state <= ACTIVE;
        end
      end else if (w_acc && s_axis.tuser) begin
        // zero-sized SOF: abandon any frame in progress
        r_state <= WAIT_SOF;
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      frame_err_cnt <= '0;
      line_err_cnt  <= '0;
    end else if (err_clr) begin
      frame_err_cnt <= '0;
      line_err_cnt  <= '0;
    end else begin
      if (w_ferr && frame_err_cnt != '1)
        frame_err_cnt <= frame_err_cnt + 1'b1;
      if (w_lerr && line_err_cnt != '1)
        line_err_cnt <= line_err_cnt + 1'b1;
    end
  end

  axis_skid_buf u_skid (
    .i_clk   (axis_aclk),
    .i_rst_n (axis_aresetn),
    .i_valid (w_fwd),
    .i_data  (w_in),
    .o_full  (w_full),
    .o_valid (w_ov),
    .i_ready (m_axis.tready),
    .o_data  (w_out)
  );

  assign m_axis.tvalid = w_ov;
  assign m_axis.tdata  = AXIS_TDATA_WIDTH'(w_out.tdata);
  assign m_axis.tuser  = w_out.tuser;
  assign m_axis.tlast  = w_out.tlast;
  assign frame_done    = r_done;
  assign busy          = (r_state == ACTIVE);

endmodule
